// File: rtl/serial_link_pkg.sv
// Shared definitions for the bit-serial parity-protected link: receiver FSM states and
// parity-sense constants used by both the checker and the generator.
package serial_link_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StData   = 2'd1,
    StParity = 2'd2
  } state_e;

  localparam int unsigned ParityEven = 0;
  localparam int unsigned ParityOdd  = 1;

endpackage

// File: rtl/serial_parity_checker_if.sv
// Serial input and parallel result signals of the parity checker.
// The master side drives the serial bits; the slave side is the checker.
interface serial_parity_checker_if #(
  parameter int unsigned DATA_W = 8
);
  logic              in_valid;
  logic              in_bit;
  logic              in_sof;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              parity_err;
  logic              busy;

  modport master (
    output in_valid, in_bit, in_sof,
    input  out_valid, out_data, parity_err, busy
  );

  modport slave (
    input  in_valid, in_bit, in_sof,
    output out_valid, out_data, parity_err, busy
  );
endinterface

// File: rtl/parity_accum.sv
// One-bit registered XOR accumulator. Clear wins over load, load wins over enable.
module parity_accum (
  input  logic clk,
  input  logic rst,
  input  logic clear_i,
  input  logic load_i,
  input  logic en_i,
  input  logic bit_i,
  output logic acc_o
);

  logic acc_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= 1'b0;
    end else if (clear_i) begin
      acc_q <= 1'b0;
    end else if (load_i) begin
      acc_q <= bit_i;
    end else if (en_i) begin
      acc_q <= acc_q ^ bit_i;
    end
  end

  assign acc_o = acc_q;

endmodule

// File: rtl/serial_parity_checker.sv
// Deserializes DATA_W data bits (LSB first) plus a trailing parity bit, then presents the
// word with a one-cycle valid pulse and a parity error flag that hold until the next frame.
module serial_parity_checker
  import serial_link_pkg::*;
#(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned ODD_PARITY = ParityEven
) (
  input logic                   clk,
  input logic                   rst,
  serial_parity_checker_if.slave bus
);

  // DATA_W of 1 would need a direct jump to StParity; the legal range starts at 2.
  localparam int unsigned     CntW    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CntW-1:0] LastIdx = CntW'(DATA_W - 1);
  localparam logic            OddBit  = ODD_PARITY[0];

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              out_valid_q, out_valid_d;
  logic              err_q, err_d;
  logic              busy_q;

  logic acc;
  logic acc_clear, acc_load, acc_en;

  parity_accum u_parity_accum (
    .clk     (clk),
    .rst     (rst),
    .clear_i (acc_clear),
    .load_i  (acc_load),
    .en_i    (acc_en),
    .bit_i   (bus.in_bit),
    .acc_o   (acc)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    shift_d     = shift_q;
    out_data_d  = out_data_q;
    out_valid_d = 1'b0;
    err_d       = err_q;
    acc_clear   = 1'b0;
    acc_load    = 1'b0;
    acc_en      = 1'b0;

    if (bus.in_valid) begin
      if (bus.in_sof) begin
        // SOF in any state starts a fresh frame; a partial frame is dropped silently.
        state_d    = StData;
        cnt_d      = CntW'(1);
        shift_d[0] = bus.in_bit;
        acc_load   = 1'b1;
      end else begin
        case (state_q)
          StData: begin
            shift_d[cnt_q] = bus.in_bit;
            acc_en         = 1'b1;
            if (cnt_q == LastIdx) begin
              state_d = StParity;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
          StParity: begin
            out_valid_d = 1'b1;
            out_data_d  = shift_q;
            err_d       = (acc ^ bus.in_bit) != OddBit;
            acc_clear   = 1'b1;
            cnt_d       = '0;
            state_d     = StIdle;
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      shift_q     <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      err_q       <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shift_q     <= shift_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      err_q       <= err_d;
      busy_q      <= (state_d != StIdle);
    end
  end

  assign bus.out_valid  = out_valid_q;
  assign bus.out_data   = out_data_q;
  assign bus.parity_err = err_q;
  assign bus.busy       = busy_q;

endmodule

// File: tb/tb_serial_parity_checker.sv
// Scoreboard bench for serial_parity_checker: an even-parity and an odd-parity instance
// driven with directed frames; monitors compare each valid pulse against queued results.
module tb_serial_parity_checker;
  import serial_link_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  serial_parity_checker_if #(.DATA_W(8)) if_e ();
  serial_parity_checker_if #(.DATA_W(8)) if_o ();

  serial_parity_checker #(.DATA_W(8), .ODD_PARITY(ParityEven)) dut_e (
    .clk (clk),
    .rst (rst),
    .bus (if_e.slave)
  );

  serial_parity_checker #(.DATA_W(8), .ODD_PARITY(ParityOdd)) dut_o (
    .clk (clk),
    .rst (rst),
    .bus (if_o.slave)
  );

  typedef struct {
    logic [7:0] data;
    logic       err;
    int         cyc;
  } exp_t;

  exp_t q_e[$];
  exp_t q_o[$];
  int   cyc = 0;
  int   n_total = 0;
  int   n_pass = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Monitors: each pulse must match the oldest queued frame, including its cycle.
  exp_t e_e;
  always @(negedge clk) begin
    if (if_e.out_valid === 1'b1) begin
      if (q_e.size() == 0) begin
        check("even unexpected pulse", 32'd1, 32'd0);
      end else begin
        e_e = q_e.pop_front();
        check("even out_data", 32'(if_e.out_data), 32'(e_e.data));
        check("even parity_err", 32'(if_e.parity_err), 32'(e_e.err));
        check("even latency", 32'(cyc), 32'(e_e.cyc));
      end
    end
  end

  exp_t e_o;
  always @(negedge clk) begin
    if (if_o.out_valid === 1'b1) begin
      if (q_o.size() == 0) begin
        check("odd unexpected pulse", 32'd1, 32'd0);
      end else begin
        e_o = q_o.pop_front();
        check("odd out_data", 32'(if_o.out_data), 32'(e_o.data));
        check("odd parity_err", 32'(if_o.parity_err), 32'(e_o.err));
        check("odd latency", 32'(cyc), 32'(e_o.cyc));
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_bit(input bit odd, input logic b, input logic sof);
    if (odd) begin
      if_o.in_valid = 1'b1;
      if_o.in_bit   = b;
      if_o.in_sof   = sof;
    end else begin
      if_e.in_valid = 1'b1;
      if_e.in_bit   = b;
      if_e.in_sof   = sof;
    end
    @(posedge clk);
    #1;
    if_e.in_valid = 1'b0;
    if_e.in_sof   = 1'b0;
    if_o.in_valid = 1'b0;
    if_o.in_sof   = 1'b0;
  endtask

  task automatic send_data(input bit odd, input logic [7:0] data, input int nbits,
                           input bit gap);
    for (int i = 0; i < nbits; i++) begin
      send_bit(odd, data[i], (i == 0));
      if (gap) idle(1);
    end
  endtask

  // Parity bit is sampled on the edge just before the push, so the pulse is due this cycle.
  task automatic send_frame(input bit odd, input logic [7:0] data, input logic p,
                            input logic err, input bit gap);
    exp_t e;
    send_data(odd, data, 8, gap);
    send_bit(odd, p, 1'b0);
    e.data = data;
    e.err  = err;
    e.cyc  = cyc;
    if (odd) q_o.push_back(e);
    else q_e.push_back(e);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish, got no end, expected end");
    $fatal(1);
  end

  initial begin
    if_e.in_valid = 1'b0; if_e.in_bit = 1'b0; if_e.in_sof = 1'b0;
    if_o.in_valid = 1'b0; if_o.in_bit = 1'b0; if_o.in_sof = 1'b0;
    rst = 1'b1;
    idle(2);
    check("reset even out_valid", 32'(if_e.out_valid), 32'd0);
    check("reset even out_data", 32'(if_e.out_data), 32'd0);
    check("reset even parity_err", 32'(if_e.parity_err), 32'd0);
    check("reset even busy", 32'(if_e.busy), 32'd0);
    check("reset odd out_valid", 32'(if_o.out_valid), 32'd0);
    check("reset odd out_data", 32'(if_o.out_data), 32'd0);
    check("reset odd parity_err", 32'(if_o.parity_err), 32'd0);
    check("reset odd busy", 32'(if_o.busy), 32'd0);
    rst = 1'b0;
    idle(1);

    // Even parity: 0xA5 has four ones.
    send_frame(1'b0, 8'hA5, 1'b0, 1'b0, 1'b0);
    check("busy low after frame", 32'(if_e.busy), 32'd0);
    idle(2);
    send_frame(1'b0, 8'hA5, 1'b1, 1'b1, 1'b0);
    idle(5);
    check("hold out_data", 32'(if_e.out_data), 32'hA5);
    check("hold parity_err", 32'(if_e.parity_err), 32'd1);
    check("hold out_valid low", 32'(if_e.out_valid), 32'd0);

    // Odd parity on all-zero data.
    send_frame(1'b1, 8'h00, 1'b1, 1'b0, 1'b0);
    idle(2);
    send_frame(1'b1, 8'h00, 1'b0, 1'b1, 1'b0);
    idle(2);

    // Gapped frame, then SOF of the next frame in the pulse cycle.
    send_frame(1'b0, 8'h3C, 1'b0, 1'b0, 1'b1);
    send_frame(1'b0, 8'h81, 1'b0, 1'b0, 1'b0);
    idle(2);

    // Abort after four bits by a new SOF.
    send_data(1'b0, 8'h0F, 4, 1'b0);
    check("busy mid frame", 32'(if_e.busy), 32'd1);
    check("abort holds out_data", 32'(if_e.out_data), 32'h81);
    send_frame(1'b0, 8'h5A, 1'b0, 1'b0, 1'b0);
    idle(2);

    // Reset mid-frame after six bits.
    send_data(1'b0, 8'h3F, 6, 1'b0);
    check("busy before reset", 32'(if_e.busy), 32'd1);
    rst = 1'b1;
    idle(1);
    check("mid reset out_valid", 32'(if_e.out_valid), 32'd0);
    check("mid reset out_data", 32'(if_e.out_data), 32'd0);
    check("mid reset parity_err", 32'(if_e.parity_err), 32'd0);
    check("mid reset busy", 32'(if_e.busy), 32'd0);
    rst = 1'b0;
    idle(1);
    send_frame(1'b0, 8'hFF, 1'b0, 1'b0, 1'b0);
    idle(3);

    check("even queue drained", 32'(q_e.size()), 32'd0);
    check("odd queue drained", 32'(q_o.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
